// File: rtl/bloom_filter_engine_if.sv
// rtl/bloom_filter_engine_if.sv - command/response bundle for the Bloom-filter engine
// Purpose: groups the command stream (in_*, flow key) and response stream (out_*,
//   insert_count) of bloom_filter_engine into one interface.
// Ports (signals):
//   in_valid/in_ready/in_op   command handshake and op (00 Q, 01 I, 10 C, 11 Q)
//   ip_pro/src_port/dest_port flow key fields
//   out_valid/out_ready       response handshake
//   out_op/out_hit            response payload
//   insert_count              saturating INSERT counter
// Modports: master drives commands and out_ready, slave is the engine.
interface bloom_filter_engine_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [71:0]      ip_pro;
  logic [15:0]      src_port;
  logic [15:0]      dest_port;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_op;
  logic             out_hit;
  logic [CNT_W-1:0] insert_count;

  modport master (
    output in_valid, in_op, ip_pro, src_port, dest_port, out_ready,
    input  in_ready, out_valid, out_op, out_hit, insert_count
  );

  modport slave (
    input  in_valid, in_op, ip_pro, src_port, dest_port, out_ready,
    output in_ready, out_valid, out_op, out_hit, insert_count
  );
endinterface

// File: rtl/bloom_filter_engine.sv
// rtl/bloom_filter_engine.sv - Bloom-filter membership engine (QUERY/INSERT/CLEAR)
// Purpose: folds a 104-bit flow key to 32 bits, derives K multiplicative-hash
//   indices into an M-bit array and probes them one per cycle; CLEAR wipes the
//   array CLR_W bits per cycle. One command in flight at a time.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      bloom_filter_engine_if.slave (command in, response out, insert_count)
module bloom_filter_engine #(
  parameter int          KEY_W     = 104,
  parameter int          M         = 256,
  parameter int          K         = 3,
  parameter int          CLR_W     = 32,
  parameter logic [31:0] SEED_BASE = 32'h2545F491,
  parameter int          CNT_W     = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  bloom_filter_engine_if.slave bus
);
  localparam int LOG2M  = $clog2(M);
  localparam int KW_PAD = ((KEY_W + 31) / 32) * 32;
  localparam int NCLR   = M / CLR_W;
  localparam int IW     = (K > 1) ? $clog2(K) : 1;
  localparam int CW     = (NCLR > 1) ? $clog2(NCLR) : 1;

  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_HASH, S_PROBE, S_CLEAR, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [31:0]      fold_q, fold_d;
  logic [IW-1:0]    i_q, i_d;
  logic [CW-1:0]    clr_q, clr_d;
  logic             hit_q, hit_d;
  logic [M-1:0]     arr_q, arr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [31:0]      seed;
  logic [31:0]      prod;
  logic [LOG2M-1:0] idx;

  function automatic logic [31:0] fold_key(input logic [KEY_W-1:0] k);
    logic [KW_PAD-1:0] padded;
    logic [31:0]       f;
    padded = KW_PAD'(k);
    f      = '0;
    for (int w = 0; w < KW_PAD / 32; w++) f = f ^ padded[w*32 +: 32];
    return f;
  endfunction

  // Hash index for the current probe; top LOG2M bits of the truncated product.
  assign seed = SEED_BASE + 32'(i_q) * 32'h7F4A7C15;
  assign prod = (fold_q ^ seed) * 32'h9E3779B1;
  assign idx  = LOG2M'(prod >> (32 - LOG2M));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    fold_d  = fold_q;
    i_d     = i_q;
    clr_d   = clr_q;
    hit_d   = hit_q;
    arr_d   = arr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          key_d   = KEY_W'({bus.ip_pro, bus.src_port, bus.dest_port});
          hit_d   = 1'b0;
          clr_d   = '0;
          state_d = (bus.in_op == OP_CLEAR) ? S_CLEAR : S_HASH;
        end
      end
      S_HASH: begin
        fold_d  = fold_key(key_q);
        hit_d   = 1'b1;
        i_d     = '0;
        state_d = S_PROBE;
      end
      S_PROBE: begin
        // Read uses the registered array, so a repeated index sees the earlier write.
        hit_d = hit_q & arr_q[idx];
        if (op_q == OP_INSERT) arr_d[idx] = 1'b1;
        if (i_q == IW'(K - 1)) begin
          state_d = S_RESP;
          if (op_q == OP_INSERT && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_CLEAR: begin
        for (int b = 0; b < M; b++) begin
          if ((b / CLR_W) == int'(clr_q)) arr_d[b] = 1'b0;
        end
        if (clr_q == CW'(NCLR - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      key_q       <= '0;
      fold_q      <= '0;
      i_q         <= '0;
      clr_q       <= '0;
      hit_q       <= 1'b0;
      arr_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      fold_q      <= fold_d;
      i_q         <= i_d;
      clr_q       <= clr_d;
      hit_q       <= hit_d;
      arr_q       <= arr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_op       = op_q;
  assign bus.out_hit      = hit_q;
  assign bus.insert_count = cnt_q;
endmodule

// File: tb/tb_bloom_filter_engine.sv
// tb/tb_bloom_filter_engine.sv - self-checking bench for bloom_filter_engine
module tb_bloom_filter_engine;
  localparam int M = 256, K = 3, LOG2M = 8, NCLR = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bloom_filter_engine_if bus ();
  bloom_filter_engine dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit model_arr[M];
  int model_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [71:0] ipp;
    logic [15:0] sp;
    logic [15:0] dp;
    int          hold;
    int          exp_hit;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_idx(input logic [103:0] key, input int i);
    longint unsigned f, seed, ii, p;
    logic [127:0] k;
    k = {24'd0, key};
    f = 0;
    for (int w = 0; w < 4; w++) f = f ^ longint'((k >> (32 * w)) & 128'hFFFF_FFFF);
    ii   = longint'(i);
    seed = (64'h2545F491 + ii * 64'h7F4A7C15) % 64'h1_0000_0000;
    p    = ((f ^ seed) * 64'h9E3779B1) % 64'h1_0000_0000;
    return int'(p / (64'd1 << (32 - LOG2M)));
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [103:0] key, output bit hit);
    int id;
    if (op == 2'b10) begin
      for (int b = 0; b < M; b++) model_arr[b] = 1'b0;
      model_cnt = 0;
      hit = 1'b0;
    end else begin
      hit = 1'b1;
      for (int i = 0; i < K; i++) begin
        id  = ref_idx(key, i);
        hit = hit & model_arr[id];
        if (op == 2'b01) model_arr[id] = 1'b1;
      end
      if (op == 2'b01 && model_cnt < 65535) model_cnt++;
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [71:0] ipp, input logic [15:0] sp,
                        input logic [15:0] dp, input int hold, input int exp_hit,
                        input int exp_cnt, input string tag);
    int cyc, w;
    bit mhit;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_wait"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.ip_pro    = ipp;
    bus.src_port  = sp;
    bus.dest_port = dp;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'($urandom);
    bus.ip_pro    = {$urandom, $urandom, 8'($urandom)};
    bus.src_port  = 16'($urandom);
    bus.dest_port = 16'($urandom);
    cyc = 1;
    check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    model_apply((op == 2'b11) ? 2'b00 : op, {ipp, sp, dp}, mhit);
    check({tag, "_latency"}, 64'(cyc), (op == 2'b10) ? 64'(NCLR + 1) : 64'(K + 2));
    check({tag, "_out_op"}, 64'(bus.out_op), 64'(op));
    check({tag, "_hit_model"}, 64'(bus.out_hit), 64'(mhit));
    check({tag, "_count_model"}, 64'(bus.insert_count), 64'(model_cnt));
    if (exp_hit >= 0) check({tag, "_hit_table"}, 64'(bus.out_hit), 64'(exp_hit));
    if (exp_cnt >= 0) check({tag, "_count_table"}, 64'(bus.insert_count), 64'(exp_cnt));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b10;
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_hit"}, 64'(bus.out_hit), 64'(mhit));
      check({tag, "_hold_op"}, 64'(bus.out_op), 64'(op));
      check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  localparam logic [71:0] KEY_IP = 72'h000001_06_C0A80001_11;

  initial begin
    logic [71:0] pool_ip[6];
    logic [15:0] pool_sp[6];
    logic [15:0] pool_dp[6];
    int r, seen;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.ip_pro    = '0;
    bus.src_port  = '0;
    bus.dest_port = '0;
    bus.out_ready = 1'b1;

    tbl[0] = '{2'b00, KEY_IP, 16'd1234, 16'd80, 0, 0, 0};
    tbl[1] = '{2'b01, KEY_IP, 16'd1234, 16'd80, 0, 0, 1};
    tbl[2] = '{2'b00, KEY_IP, 16'd1234, 16'd80, 0, 1, 1};
    tbl[3] = '{2'b01, KEY_IP, 16'd1234, 16'd80, 0, 1, 2};
    tbl[4] = '{2'b00, KEY_IP, 16'd1234, 16'd81, 0, -1, 2};
    tbl[5] = '{2'b11, KEY_IP, 16'd1234, 16'd80, 0, 1, 2};
    tbl[6] = '{2'b10, KEY_IP, 16'd1234, 16'd80, 0, 0, 0};
    tbl[7] = '{2'b00, KEY_IP, 16'd1234, 16'd80, 0, 0, 0};
    tbl[8] = '{2'b01, KEY_IP, 16'd1234, 16'd80, 6, 0, 1};

    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_op", 64'(bus.out_op), 64'd0);
    check("reset_out_hit", 64'(bus.out_hit), 64'd0);
    check("reset_count", 64'(bus.insert_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 9; t++)
      do_cmd(tbl[t].op, tbl[t].ipp, tbl[t].sp, tbl[t].dp, tbl[t].hold,
             tbl[t].exp_hit, tbl[t].exp_cnt, $sformatf("vec%0d", t));

    // Reset asserted while an INSERT is probing: no response and an empty array.
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'b01;
    bus.ip_pro    = 72'h0102030405060708_09;
    bus.src_port  = 16'd555;
    bus.dest_port = 16'd443;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_count", 64'(bus.insert_count), 64'd0);
    reset_n = 1'b1;
    for (int b = 0; b < M; b++) model_arr[b] = 1'b0;
    model_cnt = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midreset_no_response", 64'(seen), 64'd0);
    do_cmd(2'b00, 72'h0102030405060708_09, 16'd555, 16'd443, 0, 0, 0, "midreset_query");
    do_cmd(2'b00, KEY_IP, 16'd1234, 16'd80, 0, 0, 0, "midreset_query_orig");

    for (int p = 0; p < 6; p++) begin
      pool_ip[p] = {$urandom, $urandom, 8'($urandom)};
      pool_sp[p] = 16'($urandom);
      pool_dp[p] = 16'($urandom);
    end
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [1:0] op;
      k = $urandom_range(0, 5);
      r = $urandom_range(0, 19);
      if (r == 0) op = 2'b10;
      else if (r == 1) op = 2'b11;
      else if (r <= 10) op = 2'b01;
      else op = 2'b00;
      do_cmd(op, pool_ip[k], pool_sp[k], pool_dp[k], $urandom_range(0, 2), -1, -1,
             $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
